// File: rtl/alu_muldiv.sv
// Sequential multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Optional divide datapath is built only when MULDIV_DIVIDE_EN is defined.
module alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [1:0]       Operation,
    input  logic             byteWord,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             divError,
    output logic [WIDTH-1:0] resultLo,
    output logic [WIDTH-1:0] resultHi,
    output logic             F_Carry,
    output logic             F_Overflow
);
    localparam int N8 = WIDTH / 2;
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             bw_q, bw_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, shf_q, shf_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic             cf_q, cf_d, of_q, of_d, derr_q, derr_d;

    logic             sa, sb, hi_nz;
    logic [WIDTH-1:0] a_sel, b_sel, a_mag, b_mag;
    logic [W2-1:0]    prod;

`ifdef MULDIV_DIVIDE_EN
    logic [WIDTH-1:0] d_q, d_d, rem_q, rem_d;
    logic             rneg_q, rneg_d, dovf_q, dovf_d;
    logic             sdv, q_ovf;
    logic [W2-1:0]    dv_sel, dv_mag;
    logic [WIDTH-1:0] dv_hi, dv_lo, q_s, r_s;
    logic [WIDTH:0]   r_sh, r_diff;
`else
    logic d_unused;
    assign d_unused = ^D;
`endif

    always_comb begin
        // Byte operands are sign/zero extended to WIDTH before taking magnitudes.
        sa    = op_q[0] & (bw_q ? a_q[WIDTH-1] : a_q[N8-1]);
        sb    = op_q[0] & (bw_q ? b_q[WIDTH-1] : b_q[N8-1]);
        a_sel = bw_q ? a_q : {{N8{sa}}, a_q[N8-1:0]};
        b_sel = bw_q ? b_q : {{N8{sb}}, b_q[N8-1:0]};
        a_mag = sa ? -a_sel : a_sel;
        b_mag = sb ? -b_sel : b_sel;
        prod  = neg_q ? -acc_q : acc_q;
        if (op_q[0])
            hi_nz = bw_q ? (prod[W2-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                         : (prod[WIDTH-1:N8] != {N8{prod[N8-1]}});
        else
            hi_nz = bw_q ? (|prod[W2-1:WIDTH]) : (|prod[WIDTH-1:N8]);
`ifdef MULDIV_DIVIDE_EN
        sdv    = op_q[0] & (bw_q ? d_q[WIDTH-1] : a_q[WIDTH-1]);
        dv_sel = bw_q ? {d_q, a_q} : {{WIDTH{sdv}}, a_q};
        dv_mag = sdv ? -dv_sel : dv_sel;
        dv_hi  = bw_q ? dv_mag[W2-1:WIDTH] : {{N8{1'b0}}, dv_mag[WIDTH-1:N8]};
        // Low dividend bits are left-aligned so the next bit is always shf_q MSB.
        dv_lo  = bw_q ? dv_mag[WIDTH-1:0] : {dv_mag[N8-1:0], {N8{1'b0}}};
        r_sh   = {rem_q, shf_q[WIDTH-1]};
        r_diff = r_sh - {1'b0, mcand_q};
        q_ovf  = dovf_q | (op_q[0] & (bw_q ? shf_q[WIDTH-1] : shf_q[N8-1]));
        q_s    = neg_q ? -shf_q : shf_q;
        r_s    = rneg_q ? -rem_q : rem_q;
        d_d    = d_q;
        rem_d  = rem_q;
        rneg_d = rneg_q;
        dovf_d = dovf_q;
`endif
        state_d = state_q;
        op_d    = op_q;
        bw_d    = bw_q;
        a_d     = a_q;
        b_d     = b_q;
        mcand_d = mcand_q;
        shf_d   = shf_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cf_d    = cf_q;
        of_d    = of_q;
        derr_d  = derr_q;

        case (state_q)
            IDLE: if (start) begin
                state_d = SETUP;
                op_d    = Operation;
                bw_d    = byteWord;
                a_d     = A;
                b_d     = B;
                derr_d  = 1'b0;
`ifdef MULDIV_DIVIDE_EN
                d_d     = D;
`endif
            end
            SETUP: begin
                cnt_d = bw_q ? CW'(WIDTH) : CW'(N8);
                if (!op_q[1]) begin
                    state_d = ITER;
                    mcand_d = a_mag;
                    shf_d   = bw_q ? b_mag : {b_mag[N8-1:0], {N8{1'b0}}};
                    acc_d   = '0;
                    neg_d   = sa ^ sb;
                end else begin
`ifdef MULDIV_DIVIDE_EN
                    if (b_mag == '0) begin
                        state_d = DONE;
                        derr_d  = 1'b1;
                    end else begin
                        state_d = ITER;
                        mcand_d = b_mag;
                        shf_d   = dv_lo;
                        rem_d   = dv_hi;
                        dovf_d  = (dv_hi >= b_mag);
                        neg_d   = sdv ^ sb;
                        rneg_d  = sdv;
                    end
`else
                    state_d = DONE;
                    derr_d  = 1'b1;
`endif
                end
            end
            ITER: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIXUP;
                if (!op_q[1]) begin
                    acc_d = {acc_q[W2-2:0], 1'b0}
                          + (shf_q[WIDTH-1] ? {{WIDTH{1'b0}}, mcand_q} : {W2{1'b0}});
                    shf_d = shf_q << 1;
                end
`ifdef MULDIV_DIVIDE_EN
                else begin
                    shf_d = {shf_q[WIDTH-2:0], ~r_diff[WIDTH]};
                    rem_d = r_diff[WIDTH] ? r_sh[WIDTH-1:0] : r_diff[WIDTH-1:0];
                end
`endif
            end
            FIXUP: begin
                state_d = DONE;
                if (!op_q[1]) begin
                    lo_d = prod[WIDTH-1:0];
                    hi_d = bw_q ? prod[W2-1:WIDTH] : '0;
                    cf_d = hi_nz;
                    of_d = hi_nz;
                end
`ifdef MULDIV_DIVIDE_EN
                else if (q_ovf) begin
                    derr_d = 1'b1;
                end else begin
                    lo_d = bw_q ? q_s : {{N8{1'b0}}, q_s[N8-1:0]};
                    hi_d = bw_q ? r_s : {{N8{1'b0}}, r_s[N8-1:0]};
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            op_q    <= '0;
            bw_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            mcand_q <= '0;
            shf_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            derr_q  <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            d_q     <= '0;
            rem_q   <= '0;
            rneg_q  <= 1'b0;
            dovf_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            bw_q    <= bw_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mcand_q <= mcand_d;
            shf_q   <= shf_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            derr_q  <= derr_d;
`ifdef MULDIV_DIVIDE_EN
            d_q     <= d_d;
            rem_q   <= rem_d;
            rneg_q  <= rneg_d;
            dovf_q  <= dovf_d;
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign divError   = derr_q;
    assign resultLo   = lo_q;
    assign resultHi   = hi_q;
    assign F_Carry    = cf_q;
    assign F_Overflow = of_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed vectors push expectations, a monitor checks each done pulse.
module tb_alu_muldiv;
    localparam int W = 16;

    logic         CLK, RESET, start, byteWord;
    logic [1:0]   Operation;
    logic [W-1:0] A, D, B;
    logic         busy, done, divError, F_Carry, F_Overflow;
    logic [W-1:0] resultLo, resultHi;

    alu_muldiv #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .Operation(Operation),
        .byteWord(byteWord), .A(A), .D(D), .B(B), .busy(busy), .done(done),
        .divError(divError), .resultLo(resultLo), .resultHi(resultHi),
        .F_Carry(F_Carry), .F_Overflow(F_Overflow)
    );

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         cf;
        logic         of;
        logic         err;
        int           cyc;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    logic [W-1:0] m_lo = '0, m_hi = '0;
    logic         m_cf = 1'b0, m_of = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: cyc counts posedges; every done pulse must match the oldest expectation.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_done: done=1 in cycle %0d, expected no pulse", cyc);
                end else begin : pop_blk
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, ".cycle"}, cyc, e.cyc);
                    chk({e.name, ".lo"}, 32'(resultLo), 32'(e.lo));
                    chk({e.name, ".hi"}, 32'(resultHi), 32'(e.hi));
                    chk({e.name, ".cf"}, 32'(F_Carry), 32'(e.cf));
                    chk({e.name, ".of"}, 32'(F_Overflow), 32'(e.of));
                    chk({e.name, ".err"}, 32'(divError), 32'(e.err));
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (busy && n < 64) begin
            @(negedge CLK);
            n++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    // Start raised in cycle s is taken on edge s+1; done is expected in cycle s+lat.
    task automatic issue(input string nm, input logic [1:0] op, input logic bw,
                         input logic [W-1:0] a, input logic [W-1:0] d, input logic [W-1:0] b,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic ecf, input logic eof, input logic eerr, input int lat);
        exp_t e;
        wait_idle();
`ifndef MULDIV_DIVIDE_EN
        if (op[1]) begin
            eerr = 1'b1;
            lat  = 2;
        end
`endif
        if (!eerr) begin
            m_lo = elo;
            m_hi = ehi;
            if (!op[1]) begin
                m_cf = ecf;
                m_of = eof;
            end
        end
        e.lo   = m_lo;
        e.hi   = m_hi;
        e.cf   = m_cf;
        e.of   = m_of;
        e.err  = eerr;
        e.cyc  = cyc + lat;
        e.name = nm;
        sb.push_back(e);
        Operation = op;
        byteWord  = bw;
        A = a;
        D = d;
        B = b;
        start = 1'b1;
        @(negedge CLK);
        start     = 1'b0;
        Operation = ~op;
        byteWord  = ~bw;
        A = ~a;
        D = ~d;
        B = ~b;
    endtask

    initial begin
        RESET = 1'b1;
        start = 1'b0;
        Operation = 2'b00;
        byteWord = 1'b0;
        A = '0;
        D = '0;
        B = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(divError), 32'd0);
        chk("rst.lo", 32'(resultLo), 32'd0);
        chk("rst.hi", 32'(resultHi), 32'd0);
        chk("rst.cf", 32'(F_Carry), 32'd0);
        chk("rst.of", 32'(F_Overflow), 32'd0);

        //     name           op    bw  A         D         B         exp lo    exp hi    cf    of    err   lat
        issue("mul_w",       2'b00, 1, 16'h1234, 16'h0000, 16'h0100, 16'h3400, 16'h0012, 1'b1, 1'b1, 1'b0, 19);
        issue("imul_b",      2'b01, 0, 16'h00FF, 16'h0000, 16'h0002, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0, 11);
        issue("mul_b_hi",    2'b00, 0, 16'h0010, 16'h0000, 16'h0010, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 11);
        issue("imul_w_m1",   2'b01, 1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 19);
        issue("imul_w_min",  2'b01, 1, 16'h8000, 16'h0000, 16'h0002, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 19);
        issue("mul_w_max",   2'b00, 1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b1, 1'b0, 19);
        issue("div_w",       2'b10, 1, 16'h0000, 16'h0001, 16'h0010, 16'h1000, 16'h0000, 1'b0, 1'b0, 1'b0, 19);
        issue("div_w_ovf",   2'b10, 1, 16'h0000, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 19);
        issue("idiv_b",      2'b11, 0, 16'hFFF9, 16'h0000, 16'h0002, 16'h00FD, 16'h00FF, 1'b0, 1'b0, 1'b0, 11);
        issue("idiv_b_ovf",  2'b11, 0, 16'h0080, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 11);
        issue("idiv_w",      2'b11, 1, 16'hFFF9, 16'hFFFF, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 1'b0, 19);
        issue("div_b",       2'b10, 0, 16'h0064, 16'h0000, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0, 11);

        // A second start while busy must be dropped: only one done, at the original cycle.
        issue("mul_busy",    2'b00, 1, 16'h0101, 16'h0000, 16'h0100, 16'h0100, 16'h0001, 1'b1, 1'b1, 1'b0, 19);
        repeat (3) @(negedge CLK);
        Operation = 2'b00;
        byteWord  = 1'b0;
        A = 16'h7777;
        B = 16'h7777;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;

        issue("div_zero",    2'b10, 1, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 2);

        // Abort a word MUL with RESET on the 5th edge after start is raised.
        wait_idle();
        Operation = 2'b00;
        byteWord  = 1'b1;
        A = 16'h1234;
        B = 16'h5678;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        chk("abort.busy_before", 32'(busy), 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.err", 32'(divError), 32'd0);
        chk("abort.lo", 32'(resultLo), 32'd0);
        chk("abort.hi", 32'(resultHi), 32'd0);
        chk("abort.cf", 32'(F_Carry), 32'd0);
        chk("abort.of", 32'(F_Overflow), 32'd0);
        m_lo = '0;
        m_hi = '0;
        m_cf = 1'b0;
        m_of = 1'b0;
        repeat (30) @(negedge CLK);

        issue("mul_b_post",  2'b00, 0, 16'h0003, 16'h0000, 16'h0004, 16'h000C, 16'h0000, 1'b0, 1'b0, 1'b0, 11);
        issue("div_b_ovf",   2'b10, 0, 16'h0100, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 11);

        wait_idle();
        begin : drain
            int k = 0;
            while (sb.size() != 0 && k < 50) begin
                @(negedge CLK);
                k++;
            end
            if (sb.size() != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_done: %0d responses outstanding, expected 0", sb.size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the full operand/word width; even, minimum 8; byte width N8 = WIDTH/2.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1, the synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, the request strobe, sampled only in IDLE.
REQ-005 SHALL have port Operation, input, 2: 00 MUL, 01 IMUL, 10 DIV, 11 IDIV.
REQ-006 SHALL have port byteWord, input, 1: 0 selects byte mode, 1 selects word mode.
REQ-007 SHALL have port A, input, WIDTH: the multiplicand, or the dividend low word (the whole dividend in byte mode).
REQ-008 SHALL have port D, input, WIDTH: the dividend high word, used in word DIV/IDIV only.
REQ-009 SHALL have port B, input, WIDTH: the multiplier/divisor; only B[N8-1:0] is used in byte mode.
REQ-010 SHALL have output ports busy (1), done (1, single-cycle pulse) and divError (1).
REQ-011 SHALL have output ports resultLo and resultHi (WIDTH each), plus F_Carry and F_Overflow (1 each).

Function
REQ-012 SHALL implement a state machine with states IDLE, SETUP, ITER, FIXUP, DONE; busy=1 in every state except IDLE.
REQ-013 SHALL accept a request when start=1 in IDLE, capturing A, B, D, Operation and byteWord; input changes while busy are ignored.
REQ-014 SHALL ignore start while busy; no queuing.
REQ-015 SHALL step IDLE->SETUP->ITER (exactly K cycles; K=WIDTH in word mode, N8 in byte mode)->FIXUP->DONE->IDLE.
REQ-016 SHALL assert done only in DONE, i.e. K+3 cycles after the accepting edge (19 for word, 11 for byte at WIDTH=16).
REQ-017 SHALL in SETUP take magnitudes of signed operands; ITER does one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; FIXUP applies sign correction and range checks.
REQ-018 SHALL return MUL/IMUL results: word mode product {resultHi,resultLo} (2*WIDTH bits); byte mode product in resultLo, resultHi=0.
REQ-019 SHALL set F_Carry=F_Overflow=1 for MUL when the upper half of the product is nonzero, and for IMUL when the upper half is not the sign extension of the lower half; otherwise 0.
REQ-020 SHALL return DIV/IDIV results: word dividend {D,A}, byte dividend A; quotient in resultLo, remainder in resultHi, each zero-extended in byte mode.
REQ-021 SHALL truncate IDIV quotients toward zero; the remainder takes the dividend's sign.
REQ-022 SHALL detect divisor=0 in SETUP and go directly to DONE (done 2 cycles after the accepting edge) with divError=1.
REQ-023 SHALL set divError=1 in FIXUP when the quotient exceeds K bits (DIV) or lies outside -(2^(K-1)-1)..2^(K-1)-1 (IDIV).
REQ-024 SHALL leave resultLo/resultHi/F_* unchanged from the previous operation when divError=1; divError holds until the next accepted start.
REQ-025 SHALL hold results and flags stable from done until the next accepted start; F_* are unchanged by DIV/IDIV.

Reset
REQ-026 SHALL, on RESET=1 at any edge including mid-operation, enter IDLE, with busy=0, done=0, divError=0, resultLo=resultHi=0 and F_Carry=F_Overflow=0; an aborted operation never produces done.
REQ-027 SHALL give RESET priority over start on the same edge.

Configuration
REQ-028 SHALL implement DIV/IDIV as specified when macro MULDIV_DIVIDE_EN is defined.
REQ-029 SHALL, when MULDIV_DIVIDE_EN is undefined, still accept DIV/IDIV but follow SETUP->DONE, pulsing done 2 cycles after acceptance with divError=1 and results unchanged; MUL/IMUL are unaffected and no divide datapath is synthesised.

Verification (WIDTH=16, MULDIV_DIVIDE_EN defined unless stated)
REQ-030 SHALL cover: MUL word A=0x1234 B=0x0100 -> resultHi=0x0012, resultLo=0x3400, F_Carry=F_Overflow=1, done 19 cycles after start.
REQ-031 SHALL cover: IMUL byte A=0x00FF B=0x0002 -> resultLo=0xFFFE, resultHi=0, F_Carry=F_Overflow=0, done at cycle 11.
REQ-032 SHALL cover: DIV word D=0x0001 A=0x0000 B=0x0010 -> resultLo=0x1000, resultHi=0x0000, divError=0; then D=0x0010 A=0 B=0x0010 -> divError=1, results unchanged.
REQ-033 SHALL cover: IDIV byte A=0xFFF9 B=0x0002 -> resultLo=0x00FD, resultHi=0x00FF; and IDIV byte A=0x0080 B=0x00FF -> divError=1.
REQ-034 SHALL cover: DIV B=0 -> done 2 cycles after start, divError=1; the same stimulus with the macro undefined gives an identical response for any divisor.
REQ-035 SHALL cover: RESET at cycle 5 of a word MUL -> busy=0 next cycle, no done, outputs 0; start pulsed during busy -> ignored, a single done observed.
